// File: rtl/nf_id_imm_stage_pkg.sv
// Shared nf_cpu definitions for the fetch-to-decode stage: immediate-select codes,
// RV32I major opcodes and the packed entry held in the output register.
package nf_id_imm_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    I_SEL = 2'd0,
    U_SEL = 2'd1,
    B_SEL = 2'd2,
    S_SEL = 2'd3
  } imm_sel_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [11:0] imm_i;
    logic [19:0] imm_u;
    logic [11:0] imm_b;
    logic [11:0] imm_s;
    imm_sel_e    imm_src;
`ifdef NF_ID_ILLEGAL_DET_EN
    logic        illegal;
`endif
  } entry_t;

`ifdef NF_ID_ILLEGAL_DET_EN
  function automatic logic is_major_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: is_major_opcode = 1'b1;
      default:                                            is_major_opcode = 1'b0;
    endcase
  endfunction
`endif

endpackage

// File: rtl/nf_id_imm_dec.sv
// Combinational split of one instruction word into register indices, raw
// immediate fields and the nf_sign_ex select code.
import nf_id_imm_stage_pkg::*;

module nf_id_imm_dec (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output entry_t      ent
);

  always_comb begin
    ent       = '0;
    ent.instr = instr;
    ent.pc    = pc;
    ent.ra1   = instr[19:15];
    ent.ra2   = instr[24:20];
    ent.wa3   = instr[11:7];
    ent.imm_i = instr[31:20];
    ent.imm_u = instr[31:12];
    // Branch offset bit 0 is implicit zero, so only bits 12:1 are carried.
    ent.imm_b = {instr[31], instr[7], instr[30:25], instr[11:8]};
    ent.imm_s = {instr[31:25], instr[11:7]};
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: ent.imm_src = U_SEL;
      OPC_BRANCH:         ent.imm_src = B_SEL;
      OPC_STORE:          ent.imm_src = S_SEL;
      default:            ent.imm_src = I_SEL;
    endcase
`ifdef NF_ID_ILLEGAL_DET_EN
    ent.illegal = ~is_major_opcode(instr[6:0]);
`endif
  end

endmodule

// File: rtl/nf_id_imm_stage.sv
// Registered fetch-to-decode stage with a 1-entry skid buffer and flush.
// Optional illegal-opcode flag (illegal_o) when NF_ID_ILLEGAL_DET_EN is defined.
import nf_id_imm_stage_pkg::*;

module nf_id_imm_stage #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  wa3,
  output logic [11:0] imm_data_i,
  output logic [19:0] imm_data_u,
  output logic [11:0] imm_data_b,
  output logic [11:0] imm_data_s,
  output logic [1:0]  imm_src
`ifdef NF_ID_ILLEGAL_DET_EN
  ,
  output logic        illegal_o
`endif
);

  // Handshake: a word transfers on a rising edge where valid & ready are both
  // high; valid never depends on ready, and in_ready is pure register state.
  logic        out_valid_q;
  logic        skid_valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  entry_t      out_q;
  entry_t      dec_ent;
  logic [31:0] pre_instr;
  logic [31:0] pre_pc;
  logic        accept;
  logic        load_en;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign load_en  = ~out_valid_q | out_ready;

  // The skid word is older than anything on the input, so it wins the decoder.
  assign pre_instr = skid_valid_q ? skid_instr_q : instr_i;
  assign pre_pc    = skid_valid_q ? skid_pc_q    : pc_i;

  nf_id_imm_dec u_dec (
    .instr (pre_instr),
    .pc    (pre_pc),
    .ent   (dec_ent)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      out_q        <= '0;
      out_q.instr  <= NOP_INSTR;
    end else if (flush) begin
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      out_q.instr   <= NOP_INSTR;
`ifdef NF_ID_ILLEGAL_DET_EN
      out_q.illegal <= 1'b0;
`endif
    end else if (load_en) begin
      if (skid_valid_q || accept) begin
        out_q       <= dec_ent;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
        out_q.instr <= NOP_INSTR;
      end
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_instr_q <= instr_i;
      skid_pc_q    <= pc_i;
    end
  end

  assign out_valid  = out_valid_q;
  assign instr_o    = out_q.instr;
  assign pc_o       = out_q.pc;
  assign ra1        = out_q.ra1;
  assign ra2        = out_q.ra2;
  assign wa3        = out_q.wa3;
  assign imm_data_i = out_q.imm_i;
  assign imm_data_u = out_q.imm_u;
  assign imm_data_b = out_q.imm_b;
  assign imm_data_s = out_q.imm_s;
  assign imm_src    = out_q.imm_src;
`ifdef NF_ID_ILLEGAL_DET_EN
  assign illegal_o  = out_q.illegal;
`endif

endmodule

// File: tb/tb_nf_id_imm_stage.sv
// Bench for nf_id_imm_stage: a 2-deep occupancy model checked every cycle,
// plus directed vectors with hand-computed field values.
module tb_nf_id_imm_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        resetn;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [11:0] imm_data_i;
  logic [19:0] imm_data_u;
  logic [11:0] imm_data_b;
  logic [11:0] imm_data_s;
  logic [1:0]  imm_src;
`ifdef NF_ID_ILLEGAL_DET_EN
  logic        illegal_o;
`endif

  nf_id_imm_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
    .ra1        (ra1),
    .ra2        (ra2),
    .wa3        (wa3),
    .imm_data_i (imm_data_i),
    .imm_data_u (imm_data_u),
    .imm_data_b (imm_data_b),
    .imm_data_s (imm_data_s),
    .imm_src    (imm_src)
`ifdef NF_ID_ILLEGAL_DET_EN
    ,
    .illegal_o  (illegal_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  // Words currently held by the stage, oldest first: {instr, pc}.
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [31:0] w);
    case (w[6:0])
      7'b0110111, 7'b0010111: ref_sel = 2'd1;
      7'b1100011:             ref_sel = 2'd2;
      7'b0100011:             ref_sel = 2'd3;
      default:                ref_sel = 2'd0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    case (w[6:0])
      7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
      7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011: ref_illegal = 1'b0;
      default: ref_illegal = 1'b1;
    endcase
  endfunction

  // Occupancy model: the stage holds at most two words and presents the oldest.
  always @(posedge clk) begin
    if (!resetn || flush) begin
      exp_q.delete();
    end else begin
      logic acc, fr;
      acc = in_valid && (exp_q.size() < 2);
      fr  = (exp_q.size() > 0) && out_ready;
      if (fr) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({instr_i, pc_i});
        n_acc++;
      end
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      if (exp_q.size() > 0) begin
        logic [31:0] w, p;
        w = exp_q[0][63:32];
        p = exp_q[0][31:0];
        check("instr_o", instr_o, w);
        check("pc_o", pc_o, p);
        check("ra1", {27'd0, ra1}, {27'd0, w[19:15]});
        check("ra2", {27'd0, ra2}, {27'd0, w[24:20]});
        check("wa3", {27'd0, wa3}, {27'd0, w[11:7]});
        check("imm_i", {20'd0, imm_data_i}, {20'd0, w[31:20]});
        check("imm_u", {12'd0, imm_data_u}, {12'd0, w[31:12]});
        check("imm_b", {20'd0, imm_data_b}, {20'd0, w[31], w[7], w[30:25], w[11:8]});
        check("imm_s", {20'd0, imm_data_s}, {20'd0, w[31:25], w[11:7]});
        check("imm_src", {30'd0, imm_src}, {30'd0, ref_sel(w)});
`ifdef NF_ID_ILLEGAL_DET_EN
        check("illegal_o", {31'd0, illegal_o}, {31'd0, ref_illegal(w)});
`endif
      end else begin
        check("instr_o_empty", instr_o, NOP);
      end
    end
  end

  // driver
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic rdy, input logic fl);
    in_valid  = v;
    instr_i   = w;
    pc_i      = p;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opc_tab [12];

  initial begin
    opc_tab = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0110111, 7'b0010111,
                7'b1100011, 7'b0100011, 7'b0110011, 7'b1101111, 7'b0001111, 7'b0000000};
    resetn = 1'b0; in_valid = 1'b0; instr_i = '0; pc_i = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr_o", instr_o, NOP);
    check("rst_pc_o", pc_o, 32'd0);
    check("rst_fields", {ra1, ra2, wa3, imm_data_i[11:0], 5'd0}, 32'd0);
    check("rst_imm_u", {12'd0, imm_data_u}, 32'd0);
    check("rst_imm_bs", {8'd0, imm_data_b, imm_data_s}, 32'd0);
    check("rst_imm_src", {30'd0, imm_src}, 32'd0);
    resetn = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // addi x1,x0,4
    step(1'b1, 32'h0040_0093, 32'h100, 1'b1, 1'b0);
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_sel", {30'd0, imm_src}, 32'd0);
    check("addi_imm_i", {20'd0, imm_data_i}, 32'h004);
    check("addi_wa3", {27'd0, wa3}, 32'd1);
    check("addi_ra1", {27'd0, ra1}, 32'd0);
    // sw x1,-4(x2), fired-and-accepted in the same cycle: no bubble
    step(1'b1, 32'hFE11_2E23, 32'h104, 1'b1, 1'b0);
    check("sw_valid", {31'd0, out_valid}, 32'd1);
    check("sw_sel", {30'd0, imm_src}, 32'd3);
    check("sw_imm_s", {20'd0, imm_data_s}, 32'hFFC);
    check("sw_ra1", {27'd0, ra1}, 32'd2);
    check("sw_ra2", {27'd0, ra2}, 32'd1);
    // beq x0,x0,-4
    step(1'b1, 32'hFE00_0EE3, 32'h108, 1'b1, 1'b0);
    check("beq_sel", {30'd0, imm_src}, 32'd2);
    check("beq_imm_b", {20'd0, imm_data_b}, 32'hFFE);
    // lui
    step(1'b1, 32'h1234_50B7, 32'h10C, 1'b1, 1'b0);
    check("lui_sel", {30'd0, imm_src}, 32'd1);
    check("lui_imm_u", {12'd0, imm_data_u}, 32'h12345);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_instr", instr_o, NOP);

    // backpressure: A to output, B to skid
    step(1'b1, 32'h00A0_0513, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00B0_0593, 32'h204, 1'b0, 1'b0);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_a", instr_o, 32'h00A0_0513);
    step(1'b1, 32'h00C0_0613, 32'h208, 1'b0, 1'b0);
    check("bp_hold_a", instr_o, 32'h00A0_0513);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp_then_b", instr_o, 32'h00B0_0593);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // flush with skid full and an input offered the same cycle
    step(1'b1, 32'h0010_0093, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0113, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0193, 32'h308, 1'b0, 1'b1);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_instr", instr_o, NOP);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("fl_discarded", {31'd0, out_valid}, 32'd0);

`ifdef NF_ID_ILLEGAL_DET_EN
    step(1'b1, 32'h0000_0000, 32'h400, 1'b1, 1'b0);
    check("ill_zero", {31'd0, illegal_o}, 32'd1);
    step(1'b1, 32'h0040_0093, 32'h404, 1'b1, 1'b0);
    check("ill_addi", {31'd0, illegal_o}, 32'd0);
    step(1'b1, 32'h0000_0000, 32'h408, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("ill_flush", {31'd0, illegal_o}, 32'd0);
`endif

    // async reset while both entries are full
    step(1'b1, 32'h0050_0293, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h0060_0313, 32'h504, 1'b0, 1'b0);
    in_valid = 1'b0;
    resetn = 1'b0;
    #2;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_instr", instr_o, NOP);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // random streaming, 100 accepted words
    begin
      int base, cyc;
      logic [31:0] r;
      base = n_acc;
      cyc = 0;
      while ((n_acc - base) < 100 && cyc < 3000) begin
        r = $urandom();
        step(1'($urandom_range(0, 1)), {r[31:7], opc_tab[$urandom_range(0, 11)]},
             32'h1000 + 32'(cyc) * 4, 1'($urandom_range(0, 1)), 1'b0);
        cyc++;
      end
      check("stream_accepted", 32'(n_acc - base), 32'd100);
      cyc = 0;
      while (out_valid && cyc < 10) begin
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc++;
      end
      check("stream_drained", {31'd0, out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
